// File: rtl/seq_alu_pkg.sv
// Shared opcode and FSM state encodings for the sequential ALU.
package seq_alu_pkg;

    typedef enum logic [2:0] {
        OP_HOLD    = 3'b000,
        OP_AND     = 3'b001,
        OP_ADD     = 3'b010,
        OP_NOR     = 3'b011,
        OP_SUB     = 3'b100,
        OP_ADC     = 3'b101,
        OP_MUL     = 3'b110,
        OP_ILLEGAL = 3'b111
    } op_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/seq_alu_mul.sv
// Iterative shift-add multiplier: one partial product per cycle after start.
module seq_alu_mul #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [2*WIDTH-1:0] r_mcand;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_mplier;
    logic [CW-1:0]      r_cnt;
    logic               r_busy;
    logic [2*WIDTH-1:0] w_acc_next;

    // product exposes the final accumulation combinationally so the owner can
    // capture it on the same edge as the last iteration.
    assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    assign done       = r_busy && (r_cnt == CW'(WIDTH - 1));
    assign product    = w_acc_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy   <= 1'b0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
        end else if (start) begin
            r_busy   <= 1'b1;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= {{WIDTH{1'b0}}, a};
            r_mplier <= b;
        end else if (r_busy) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CW'(1);
            if (done) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arith ops plus a WIDTH-cycle multiply.
// Handshake: a request is taken on a rising edge with in_valid && in_ready.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       opcode,
    input  logic             use_acc,
    output logic             out_valid,
    output logic [WIDTH-1:0] c,
    output logic             cf,
    output logic             zf,
    output logic             sf,
    output logic             of,
    output logic             err,
    output logic             dbg_state
);

    state_t             r_state, w_state_next;
    logic [WIDTH-1:0]   r_c;
    logic               r_cf, r_zf, r_sf, r_of, r_err, r_out_valid;

    op_t                w_op;
    logic               w_accept;
    logic               w_mul_start;
    logic               w_mul_done;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_a;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_diff;
    logic [WIDTH-1:0]   w_res;
    logic               w_cf, w_zf, w_sf, w_of, w_err_set;

    assign w_op      = op_t'(opcode);
    assign in_ready  = (r_state == ST_IDLE) && !reset;
    assign w_accept  = in_valid && in_ready;
    assign w_a       = use_acc ? r_c : a;
    assign dbg_state = r_state;

    seq_alu_mul #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (w_mul_start),
        .a       (w_a),
        .b       (b),
        .done    (w_mul_done),
        .product (w_prod)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_mul_start  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && w_op == OP_MUL) begin
                    w_state_next = ST_MUL;
                    w_mul_start  = 1'b1;
                end
            end
            ST_MUL: begin
                if (w_mul_done) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Carry-in only participates for ADC; the old carry is the registered one.
    assign w_sum  = {1'b0, w_a} + {1'b0, b} + {{WIDTH{1'b0}}, (w_op == OP_ADC) && r_cf};
    assign w_diff = {1'b0, w_a} - {1'b0, b};

    always_comb begin
        w_res     = r_c;
        w_cf      = r_cf;
        w_of      = r_of;
        w_zf      = r_zf;
        w_sf      = r_sf;
        w_err_set = 1'b0;
        case (w_op)
            OP_AND: begin
                w_res = w_a & b;
                w_cf  = 1'b0;
                w_of  = 1'b0;
            end
            OP_NOR: begin
                w_res = ~(w_a | b);
                w_cf  = 1'b0;
                w_of  = 1'b0;
            end
            OP_ADD, OP_ADC: begin
                w_res = w_sum[WIDTH-1:0];
                w_cf  = w_sum[WIDTH];
                w_of  = (w_a[WIDTH-1] == b[WIDTH-1]) && (w_res[WIDTH-1] != w_a[WIDTH-1]);
            end
            OP_SUB: begin
                w_res = w_diff[WIDTH-1:0];
                w_cf  = w_diff[WIDTH];
                w_of  = (w_a[WIDTH-1] != b[WIDTH-1]) && (w_res[WIDTH-1] != w_a[WIDTH-1]);
            end
            OP_ILLEGAL: w_err_set = 1'b1;
            default: ;
        endcase
        // HOLD falls through here too: it keeps c but re-derives zf/sf from it.
        if (w_op != OP_ILLEGAL) begin
            w_zf = (w_res == '0);
            w_sf = w_res[WIDTH-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_c         <= '0;
            r_cf        <= 1'b0;
            r_zf        <= 1'b1;
            r_sf        <= 1'b0;
            r_of        <= 1'b0;
            r_err       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            if (w_accept && w_op != OP_MUL) begin
                r_out_valid <= 1'b1;
                r_c         <= w_res;
                r_cf        <= w_cf;
                r_zf        <= w_zf;
                r_sf        <= w_sf;
                r_of        <= w_of;
                if (w_err_set) begin
                    r_err <= 1'b1;
                end
            end else if (r_state == ST_MUL && w_mul_done) begin
                r_out_valid <= 1'b1;
                r_c         <= w_prod[WIDTH-1:0];
                r_cf        <= |w_prod[2*WIDTH-1:WIDTH];
                r_zf        <= (w_prod[WIDTH-1:0] == '0);
                r_sf        <= w_prod[WIDTH-1];
                r_of        <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign c         = r_c;
    assign cf        = r_cf;
    assign zf        = r_zf;
    assign sf        = r_sf;
    assign of        = r_of;
    assign err       = r_err;

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: directed scenarios then random traffic against an
// arithmetic reference model; results are matched by a queue-based monitor.
module tb_seq_alu;

    localparam int W = 8;
    localparam int M = 2 ** W;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [2:0]   opcode = '0;
    logic         use_acc = 1'b0;
    logic         out_valid;
    logic [W-1:0] c;
    logic         cf, zf, sf, of, err;
    logic         dbg_state;

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;

    logic [31:0] exp_q[$];

    int m_c, m_cf, m_zf, m_sf, m_of, m_err, m_busy_end;

    seq_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .opcode    (opcode),
        .use_acc   (use_acc),
        .out_valid (out_valid),
        .c         (c),
        .cf        (cf),
        .zf        (zf),
        .sf        (sf),
        .of        (of),
        .err       (err),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt++;

    function automatic logic [31:0] pack(input int e, input int cv, input int fc,
                                         input int fz, input int fs, input int fo,
                                         input int fe);
        logic [31:0] w;
        w = {e[18:0], cv[7:0], fc[0], fz[0], fs[0], fo[0], fe[0]};
        return w;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    function automatic int to_signed(input int v);
        return (v >= M / 2) ? v - M : v;
    endfunction

    function automatic int ovf(input int s);
        return (s > M / 2 - 1 || s < -(M / 2)) ? 1 : 0;
    endfunction

    // Reference model: updated at acceptance; pushes the expected outcome with
    // the edge number on which it must appear.
    task automatic model_accept(input int k, input int op, input int av, input int bv, input bit ua);
        int va, vb, s, arrive;
        va = ua ? m_c : av % M;
        vb = bv % M;
        arrive = k;
        case (op)
            0: ;
            1: begin m_c = va & vb; m_cf = 0; m_of = 0; end
            3: begin m_c = (~(va | vb)) & (M - 1); m_cf = 0; m_of = 0; end
            2: begin
                s = va + vb;
                m_of = ovf(to_signed(va) + to_signed(vb));
                m_c = s % M; m_cf = (s >= M) ? 1 : 0;
            end
            5: begin
                s = va + vb + m_cf;
                m_of = ovf(to_signed(va) + to_signed(vb) + m_cf);
                m_c = s % M; m_cf = (s >= M) ? 1 : 0;
            end
            4: begin
                m_of = ovf(to_signed(va) - to_signed(vb));
                m_cf = (va < vb) ? 1 : 0;
                m_c = (va - vb + M) % M;
            end
            6: begin
                s = va * vb;
                m_c = s % M; m_cf = (s >= M) ? 1 : 0; m_of = 0;
                arrive = k + W;
                m_busy_end = k + W;
            end
            default: m_err = 1;
        endcase
        if (op != 7) begin
            m_zf = (m_c == 0) ? 1 : 0;
            m_sf = (m_c >= M / 2) ? 1 : 0;
        end
        exp_q.push_back(pack(arrive, m_c, m_cf, m_zf, m_sf, m_of, m_err));
    endtask

    task automatic step(input bit v, input int op, input int av, input int bv, input bit ua);
        int e;
        bit rdy_exp;
        @(negedge clk);
        e = edge_cnt;
        rdy_exp = (e >= m_busy_end);
        check("in_ready", {31'b0, in_ready}, {31'b0, rdy_exp});
        in_valid = v;
        opcode   = op[2:0];
        a        = av[W-1:0];
        b        = bv[W-1:0];
        use_acc  = ua;
        if (v && rdy_exp) model_accept(e + 1, op, av, bv, ua);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 0, 0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        check("reset_state", {18'b0, c, cf, zf, sf, of, err, out_valid},
              {18'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        check("ready_in_reset", {31'b0, in_ready}, 32'd0);
        reset = 1'b0;
        m_c = 0; m_cf = 0; m_zf = 1; m_sf = 0; m_of = 0; m_err = 0; m_busy_end = 0;
        exp_q.delete();
    endtask

    always @(negedge clk) begin
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out_valid: got c=%h at edge %0d, required no pulse", c, edge_cnt);
            end else begin
                check("result", pack(edge_cnt, c, cf, zf, sf, of, err), exp_q.pop_front());
            end
        end
    end

    initial begin
        m_c = 0; m_cf = 0; m_zf = 1; m_sf = 0; m_of = 0; m_err = 0; m_busy_end = 0;
        do_reset();

        step(1'b1, 2, 'hF0, 'h20, 1'b0);
        idle(1);
        step(1'b1, 4, 'h05, 'h07, 1'b0);
        step(1'b1, 5, 'h00, 'h01, 1'b1);
        step(1'b1, 2, 'h7F, 'h01, 1'b0);
        step(1'b1, 1, 'h3C, 'h0F, 1'b0);
        step(1'b1, 3, 'h3C, 'h0F, 1'b0);
        step(1'b1, 0, 'hAA, 'h55, 1'b0);

        step(1'b1, 6, 'h10, 'h11, 1'b0);
        for (int i = 0; i < W; i++) step(1'b1, 2, 'h01, 'h01, 1'b0);
        idle(2);

        step(1'b1, 6, 'h10, 'h11, 1'b0);
        idle(2);
        do_reset();
        idle(1);

        step(1'b1, 2, 'h12, 'h34, 1'b0);
        step(1'b1, 7, 'hFF, 'hFF, 1'b0);
        step(1'b1, 2, 'h01, 'h02, 1'b0);
        step(1'b1, 6, 'h03, 'h05, 1'b1);
        idle(W + 1);
        step(1'b1, 0, 'h00, 'h00, 1'b0);
        do_reset();

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 3) != 0,
                     ($urandom_range(0, 19) == 0) ? 7 : $urandom_range(0, 6),
                     $urandom_range(0, M - 1), $urandom_range(0, M - 1),
                     $urandom_range(0, 2) == 0);
            end
        end

        idle(W + 4);
        check("drain", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter WIDTH, default 8, meaning operand/result width in bits (legal range 4..32).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  operation request present.
REQ-005 in_ready  output  1  block can accept a request this cycle.
REQ-006 a, b  input  WIDTH  unsigned operands.
REQ-007 opcode  input  3  operation select.
REQ-008 use_acc  input  1  when 1, operand A is taken from the registered result c, not from a.
REQ-009 out_valid  output  1  one-cycle pulse when c and flags are updated by an accepted operation.
REQ-010 c  output  WIDTH  registered result.
REQ-011 cf, zf, sf, of  output  1 each  carry, zero, sign and signed-overflow flags, registered.
REQ-012 err  output  1  sticky illegal-opcode flag.

Function
REQ-013 A request SHALL be accepted on a rising edge where in_valid=1 and in_ready=1; in_ready SHALL equal (state==IDLE) and reset==0.
REQ-014 Opcodes: 000 HOLD, 001 AND, 010 ADD, 011 NOR, 100 SUB, 101 ADC, 110 MUL, 111 illegal.
REQ-015 Single-cycle ops (000-101, 111) SHALL update c/flags and pulse out_valid on the same edge that accepts them (latency 1).
REQ-016 HOLD: c, cf and of unchanged; zf/sf recomputed from c; out_valid pulses.
REQ-017 AND/NOR: c = A&B or ~(A|B); cf=0; of=0.
REQ-018 ADD: {cf,c} = A+B computed at WIDTH+1 bits; of = signed overflow of the addition.
REQ-019 ADC: {cf,c} = A+B+cf(old); of as for ADD.
REQ-020 SUB: c = A-B modulo 2^WIDTH; cf=1 iff A<B unsigned (borrow); of = signed overflow of the subtraction.
REQ-021 MUL: c = low WIDTH bits of A*B; cf=1 iff high WIDTH bits nonzero; of=0.
REQ-022 MUL SHALL be iterative shift-add: accept edge k enters state MUL; result, flags and out_valid SHALL appear on edge k+WIDTH; in_ready=0 during cycles k+1..k+WIDTH.
REQ-023 The FSM SHALL have states IDLE and MUL: IDLE->MUL on accepted MUL; MUL->IDLE after WIDTH iterations; all other ops stay in IDLE.
REQ-024 For all non-HOLD legal ops: zf = (c==0) and sf = c[WIDTH-1], evaluated on the new c.
REQ-025 Illegal opcode: c and all flags SHALL be unchanged, err SHALL be set to 1 and stay set until reset, and out_valid SHALL pulse.
REQ-026 With use_acc=1, A SHALL be c as registered before the accepting edge; for MUL, A is captured at acceptance.
REQ-027 Operands and opcode SHALL be sampled only at acceptance; changes during MUL have no effect.
REQ-028 in_valid while in_ready=0 SHALL be ignored; there is no queueing.
REQ-029 out_valid SHALL be 0 on every edge that does not complete an operation.

Reset
REQ-030 On an edge with reset=1: c=0, cf=0, zf=1, sf=0, of=0, err=0, out_valid=0, state=IDLE.
REQ-031 Reset SHALL take priority over acceptance and over MUL completion.
REQ-032 Reset during MUL SHALL abort the multiply with no out_valid pulse; in_ready=1 on the first cycle after reset deasserts.

Structure
REQ-033 Package seq_alu_pkg SHALL hold the opcode enum (OP_HOLD..OP_ILLEGAL) and the FSM state enum.
REQ-034 The multiplier SHALL be a sub-module seq_alu_mul (start, operands in; done, 2*WIDTH-bit product out), and seq_alu owns the FSM, flags and handshake.

Verification (WIDTH=8)
REQ-035 ADD a=0xF0 b=0x20 -> next edge c=0x10, cf=1, zf=0, sf=0, of=0, out_valid=1 for one cycle.
REQ-036 SUB a=0x05 b=0x07 -> c=0xFE, cf=1, sf=1; then ADC use_acc=1 b=0x01 -> c=0x00, cf=1, zf=1.
REQ-037 ADD a=0x7F b=0x01 -> c=0x80, of=1, sf=1, cf=0.
REQ-038 MUL a=0x10 b=0x11 -> in_ready low 8 cycles; then c=0x10, cf=1, out_valid on edge k+8; an ADD presented mid-MUL is ignored.
REQ-039 Reset asserted at cycle k+3 of a MUL -> no out_valid; reset values per REQ-030; in_ready=1 on the cycle after release.
REQ-040 opcode=111 after an ADD -> c and flags unchanged, err=1, out_valid pulse; err stays 1 through later legal ops until reset.
